// File: rtl/system_mem_loader_if.sv
// Byte-stream input and system-memory write bus of the memory loader.
// The master modport is the loader side; slave is the stream source / memory side.
interface system_mem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        tbCTRL;
    logic        WEN;
    logic        REN;
    logic [31:0] addr;
    logic [31:0] store;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, tbCTRL, WEN, REN, addr, store
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, tbCTRL, WEN, REN, addr, store
    );
endinterface

// File: rtl/system_mem_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them to
// consecutive word addresses of system memory while the CPU is held off.
module system_mem_loader #(
    parameter int WRITE_CYCLES = 2,
    parameter int ADDR_STRIDE  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 load_start,
    input  logic [15:0]          base_addr,
    input  logic [15:0]          word_count,
    system_mem_loader_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          words_written,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] count_q;
    logic [1:0]  byte_idx;
    logic [3:0]  wait_cnt;

    localparam logic [3:0] LAST_WAIT = 4'(WRITE_CYCLES - 1);

    assign bus.REN   = 1'b0;
    assign state_dbg = state;

    // Stream handshake: a byte moves on a rising edge where byte_valid and
    // byte_ready are both high; byte_valid may drop at any time (stall), and
    // byte_ready is registered and high only in COLLECT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            count_q        <= '0;
            byte_idx       <= '0;
            wait_cnt       <= '0;
            bus.byte_ready <= 1'b0;
            bus.tbCTRL     <= 1'b0;
            bus.WEN        <= 1'b0;
            bus.addr       <= '0;
            bus.store      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            words_written  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load_start) begin
                        words_written <= '0;
                        bus.tbCTRL    <= 1'b1;
                        busy          <= 1'b1;
                        if (word_count != 16'd0) begin
                            count_q        <= word_count;
                            bus.addr       <= {16'b0, base_addr};
                            byte_idx       <= '0;
                            bus.byte_ready <= 1'b1;
                            state          <= COLLECT;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                COLLECT: begin
                    if (bus.byte_valid && bus.byte_ready) begin
                        bus.store[{byte_idx, 3'b000} +: 8] <= bus.byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            bus.byte_ready <= 1'b0;
                            bus.WEN        <= 1'b1;
                            wait_cnt       <= '0;
                            state          <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (wait_cnt == LAST_WAIT) begin
                        bus.WEN       <= 1'b0;
                        words_written <= words_written + 16'd1;
                        if ((words_written + 16'd1) == count_q) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            bus.addr       <= bus.addr + 32'(ADDR_STRIDE);
                            byte_idx       <= '0;
                            bus.byte_ready <= 1'b1;
                            state          <= COLLECT;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    bus.tbCTRL <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_system_mem_loader.sv
// Scoreboard bench for system_mem_loader: expected {addr,store} writes are
// queued when a load is driven and compared when WEN rises.
module tb_system_mem_loader;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- DUT with WRITE_CYCLES=2 ----------------
  system_mem_loader_if bus0();
  logic        load_start0;
  logic [15:0] base0, count0, ww0;
  logic        busy0, done0;
  logic [1:0]  st0;

  system_mem_loader #(.WRITE_CYCLES(2), .ADDR_STRIDE(4)) dut (
    .CLK(CLK), .RST(RST), .load_start(load_start0), .base_addr(base0),
    .word_count(count0), .bus(bus0.master), .busy(busy0), .done(done0),
    .words_written(ww0), .state_dbg(st0)
  );

  // ---------------- DUT with WRITE_CYCLES=1 ----------------
  system_mem_loader_if bus1();
  logic        load_start1;
  logic [15:0] base1, count1, ww1;
  logic        busy1, done1;
  logic [1:0]  st1;

  system_mem_loader #(.WRITE_CYCLES(1), .ADDR_STRIDE(4)) dut1 (
    .CLK(CLK), .RST(RST), .load_start(load_start1), .base_addr(base1),
    .word_count(count1), .bus(bus1.master), .busy(busy1), .done(done1),
    .words_written(ww1), .state_dbg(st1)
  );

  // ---------------- scoreboards / monitors ----------------
  logic [63:0] exp_q[$];
  logic [63:0] exp1_q[$];

  int          len0 = 0, overlap0 = 0, unstable0 = 0;
  logic        prev0 = 1'b0;
  logic [63:0] held0;

  always @(negedge CLK) begin
    logic [63:0] e;
    if (RST) begin
      len0  = 0;
      prev0 = 1'b0;
    end else begin
      if (bus0.WEN && bus0.byte_ready) overlap0++;
      if (bus0.WEN && !prev0) begin
        if (exp_q.size() == 0) begin
          check("write_queue_empty", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 64'(bus0.addr), 64'(e[63:32]));
          check("write_data", 64'(bus0.store), 64'(e[31:0]));
        end
        held0 = {bus0.addr, bus0.store};
      end
      if (bus0.WEN && prev0 && ({bus0.addr, bus0.store} !== held0)) unstable0++;
      if (!bus0.WEN && prev0) check("wen_width", 64'(len0), 64'd2);
      len0  = bus0.WEN ? len0 + 1 : 0;
      prev0 = bus0.WEN;
    end
  end

  int          len1 = 0, rises1 = 0;
  logic        prev1 = 1'b0;
  int unsigned last_rise1 = 0;

  always @(negedge CLK) begin
    logic [63:0] e;
    if (RST) begin
      len1  = 0;
      prev1 = 1'b0;
    end else begin
      if (bus1.WEN && !prev1) begin
        if (rises1 > 0) check("wc1_wen_gap", 64'(cyc - last_rise1), 64'd5);
        last_rise1 = cyc;
        rises1++;
        if (exp1_q.size() == 0) begin
          check("wc1_write_queue_empty", 64'(exp1_q.size()), 64'd1);
        end else begin
          e = exp1_q.pop_front();
          check("wc1_write_addr", 64'(bus1.addr), 64'(e[63:32]));
          check("wc1_write_data", 64'(bus1.store), 64'(e[31:0]));
        end
      end
      if (!bus1.WEN && prev1) check("wc1_wen_width", 64'(len1), 64'd1);
      len1  = bus1.WEN ? len1 + 1 : 0;
      prev1 = bus1.WEN;
    end
  end

  // ---------------- driver tasks (called at posedge+#1) ----------------
  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic start_load(input logic [15:0] b, input logic [15:0] c);
    load_start0 = 1'b1;
    base0       = b;
    count0      = c;
    next_cycle();
    load_start0 = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int stall_pct);
    logic acc;
    acc = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if ($urandom_range(99) >= stall_pct) break;
      bus0.byte_valid = 1'b0;
      next_cycle();
    end
    bus0.byte_valid = 1'b1;
    bus0.byte_data  = d;
    for (int t = 0; t < 50; t++) begin
      acc = bus0.byte_ready;
      next_cycle();
      if (acc) break;
    end
    if (!acc) check("byte_accept_timeout", 64'(acc), 64'd1);
    bus0.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int stall_pct);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], stall_pct);
    check("wen_one_cycle_after_last_byte", 64'(bus0.WEN), 64'd1);
  endtask

  task automatic wait_done(input logic [15:0] exp_ww);
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (done0) begin
        seen = 1'b1;
        break;
      end
      next_cycle();
    end
    check("done_seen", 64'(seen), 64'd1);
    check("tbctrl_in_done", 64'(bus0.tbCTRL), 64'd1);
    check("wen_low_in_done", 64'(bus0.WEN), 64'd0);
    check("words_written", 64'(ww0), 64'(exp_ww));
    next_cycle();
    check("done_single_pulse", 64'(done0), 64'd0);
    check("tbctrl_released", 64'(bus0.tbCTRL), 64'd0);
    check("busy_released", 64'(busy0), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    load_start0 = 1'b0; base0 = '0; count0 = '0;
    bus0.byte_valid = 1'b0; bus0.byte_data = '0;
    load_start1 = 1'b0; base1 = '0; count1 = '0;
    bus1.byte_valid = 1'b0; bus1.byte_data = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_state", 64'(st0), 64'd0);
    check("rst_outputs", 64'({bus0.byte_ready, bus0.tbCTRL, bus0.WEN, bus0.REN, busy0, done0}), 64'd0);
    check("rst_addr_store", {bus0.addr, bus0.store}, 64'd0);
    check("rst_words_written", 64'(ww0), 64'd0);
    RST = 1'b0;
    next_cycle();

    // Single word
    start_load(16'h0010, 16'd1);
    check("tbctrl_after_start", 64'(bus0.tbCTRL), 64'd1);
    check("collect_byte_ready", 64'(bus0.byte_ready), 64'd1);
    exp_q.push_back({32'h0000_0010, 32'hDEAD_BEEF});
    send_word(32'hDEAD_BEEF, 0);
    wait_done(16'd1);
    check("addr_kept_after_done", 64'(bus0.addr), 64'h10);
    check("store_kept_after_done", 64'(bus0.store), 64'hDEAD_BEEF);
    check("idle_byte_ready_low", 64'(bus0.byte_ready), 64'd0);

    // Multi-word with random stalls
    start_load(16'h0100, 16'd3);
    exp_q.push_back({32'h0000_0100, 32'h0302_0100});
    exp_q.push_back({32'h0000_0104, 32'h0706_0504});
    exp_q.push_back({32'h0000_0108, 32'h0B0A_0908});
    send_word(32'h0302_0100, 50);
    send_word(32'h0706_0504, 50);
    send_word(32'h0B0A_0908, 50);
    wait_done(16'd3);

    // Zero count
    start_load(16'h0020, 16'd0);
    check("zero_count_done_latency", 64'(done0), 64'd1);
    wait_done(16'd0);

    // Start together with a valid byte: byte must not be consumed in IDLE
    bus0.byte_valid = 1'b1;
    bus0.byte_data  = 8'hFF;
    start_load(16'h0040, 16'd1);
    bus0.byte_valid = 1'b0;
    exp_q.push_back({32'h0000_0040, 32'h1234_5678});
    send_word(32'h1234_5678, 0);
    wait_done(16'd1);

    // Ignored restart mid-load
    start_load(16'h0200, 16'd2);
    exp_q.push_back({32'h0000_0200, 32'h1122_3344});
    exp_q.push_back({32'h0000_0204, 32'h5566_7788});
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    start_load(16'h3000, 16'd5);
    send_byte(8'h22, 0);
    send_byte(8'h11, 0);
    check("restart_wen_latency", 64'(bus0.WEN), 64'd1);
    start_load(16'h3000, 16'd5);
    send_word(32'h5566_7788, 0);
    wait_done(16'd2);

    // Reset while WEN is asserted
    start_load(16'h0400, 16'd1);
    send_word(32'hCAFE_F00D, 0);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_wen", 64'(bus0.WEN), 64'd0);
    check("rst_mid_tbctrl", 64'(bus0.tbCTRL), 64'd0);
    check("rst_mid_state", 64'(st0), 64'd0);
    check("rst_mid_words_written", 64'(ww0), 64'd0);
    check("rst_mid_store", 64'(bus0.store), 64'd0);
    next_cycle();
    next_cycle();
    RST = 1'b0;
    next_cycle();
    start_load(16'h0500, 16'd1);
    check("fresh_words_written", 64'(ww0), 64'd0);
    check("fresh_addr", 64'(bus0.addr), 64'h500);
    exp_q.push_back({32'h0000_0500, 32'hA5A5_5A5A});
    send_word(32'hA5A5_5A5A, 25);
    wait_done(16'd1);

    // WRITE_CYCLES=1 instance, continuous valid
    load_start1 = 1'b1; base1 = 16'h0000; count1 = 16'd2;
    next_cycle();
    load_start1 = 1'b0;
    exp1_q.push_back({32'h0000_0000, 32'h0302_0100});
    exp1_q.push_back({32'h0000_0004, 32'h0706_0504});
    bus1.byte_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic acc;
      acc = 1'b0;
      bus1.byte_data = 8'(k);
      for (int t = 0; t < 20; t++) begin
        acc = bus1.byte_ready;
        next_cycle();
        if (acc) break;
      end
      if (!acc) check("wc1_byte_accept_timeout", 64'(acc), 64'd1);
    end
    bus1.byte_valid = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (done1) break;
      next_cycle();
    end
    check("wc1_done", 64'(done1), 64'd1);
    check("wc1_words_written", 64'(ww1), 64'd2);
    repeat (3) next_cycle();

    check("ready_wen_overlap", 64'(overlap0), 64'd0);
    check("addr_store_stable_in_write", 64'(unstable0), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp1_q_drained", 64'(exp1_q.size()), 64'd0);
    check("wc1_write_count", 64'(rises1), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
